// File: rtl/traffic_light_pkg.sv
// Shared definitions for the traffic light controllers: state encoding,
// default phase durations and phase timer sizing.
package traffic_light_pkg;

  typedef enum logic [1:0] {
    ALLRED = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    WALK   = 2'd3
  } state_t;

  localparam int DEF_NUM_DIRS     = 2;
  localparam int DEF_GRN_TICKS    = 8;
  localparam int DEF_YLW_TICKS    = 3;
  localparam int DEF_ALLRED_TICKS = 1;
  localparam int DEF_WALK_TICKS   = 6;

  // Timer holds DURATION-1, so the longest phase needs clog2(max) bits (min 1).
  function automatic int timer_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/traffic_light_multi_phase_timer.sv
// Loadable phase down-counter; done pulses on a tick when the count is zero.
module phase_timer #(
  parameter int               WIDTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count;

  assign done = tick && (count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= RESET_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/traffic_light_multi.sv
// Round-robin N-approach traffic light with latched pedestrian requests
// served in an exclusive all-red walk phase.
module traffic_light_multi
  import traffic_light_pkg::*;
#(
  parameter int NUM_DIRS     = DEF_NUM_DIRS,
  parameter int GRN_TICKS    = DEF_GRN_TICKS,
  parameter int YLW_TICKS    = DEF_YLW_TICKS,
  parameter int ALLRED_TICKS = DEF_ALLRED_TICKS,
  parameter int WALK_TICKS   = DEF_WALK_TICKS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic [NUM_DIRS-1:0] ped_req,
  output logic [NUM_DIRS-1:0] red,
  output logic [NUM_DIRS-1:0] ylw,
  output logic [NUM_DIRS-1:0] grn,
  output logic [NUM_DIRS-1:0] walk,
  output logic [NUM_DIRS-1:0] ped_pending,
  output logic [((NUM_DIRS > 2) ? $clog2(NUM_DIRS) : 1)-1:0] phase,
  output logic                debug
);

  localparam int PW = (NUM_DIRS > 2) ? $clog2(NUM_DIRS) : 1;
  localparam int TW = timer_width(GRN_TICKS, YLW_TICKS, ALLRED_TICKS, WALK_TICKS);

  localparam logic [TW-1:0] GRN_LD    = TW'(GRN_TICKS - 1);
  localparam logic [TW-1:0] YLW_LD    = TW'(YLW_TICKS - 1);
  localparam logic [TW-1:0] ALLRED_LD = TW'(ALLRED_TICKS - 1);
  localparam logic [TW-1:0] WALK_LD   = TW'(WALK_TICKS - 1);
  localparam logic [NUM_DIRS-1:0] ONE = NUM_DIRS'(1);
  localparam logic [PW-1:0] LAST_DIR  = PW'(NUM_DIRS - 1);

  state_t              state, state_nx;
  logic [PW-1:0]       phase_nx;
  logic                walked, walked_nx;
  logic [NUM_DIRS-1:0] mask, mask_nx;
  logic [NUM_DIRS-1:0] clear, pend_nx, sel;
  logic [NUM_DIRS-1:0] red_nx, ylw_nx, grn_nx, walk_nx;
  logic                debug_nx;
  logic                done;
  logic [TW-1:0]       load_val;

  phase_timer #(
    .WIDTH     (TW),
    .RESET_VAL (ALLRED_LD)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .load     (done),
    .load_val (load_val),
    .done     (done)
  );

  always_comb begin
    state_nx  = state;
    phase_nx  = phase;
    walked_nx = walked;
    mask_nx   = mask;
    clear     = '0;
    case (state)
      ALLRED: begin
        if (done) begin
          if (!walked && (ped_pending != '0)) begin
            state_nx = WALK;
            mask_nx  = ped_pending;
            clear    = ped_pending;
          end else begin
            state_nx  = GREEN;
            phase_nx  = (phase == LAST_DIR) ? '0 : phase + 1'b1;
            walked_nx = 1'b0;
          end
        end
      end
      GREEN:   if (done) state_nx = YELLOW;
      YELLOW:  if (done) state_nx = ALLRED;
      WALK: begin
        if (done) begin
          state_nx  = ALLRED;
          walked_nx = 1'b1;
        end
      end
      default: state_nx = ALLRED;
    endcase

    pend_nx = (ped_pending & ~clear) | ped_req;

    case (state_nx)
      GREEN:   load_val = GRN_LD;
      YELLOW:  load_val = YLW_LD;
      WALK:    load_val = WALK_LD;
      default: load_val = ALLRED_LD;
    endcase

    // Lamps are decoded from the next state so they change with the state edge.
    sel      = ONE << phase_nx;
    red_nx   = '1;
    ylw_nx   = '0;
    grn_nx   = '0;
    walk_nx  = '0;
    debug_nx = 1'b1;
    case (state_nx)
      GREEN: begin
        grn_nx   = sel;
        red_nx   = ~sel;
        debug_nx = 1'b0;
      end
      YELLOW: begin
        ylw_nx   = sel;
        red_nx   = ~sel;
        debug_nx = 1'b0;
      end
      WALK:    walk_nx = mask_nx;
      default: walk_nx = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ALLRED;
      phase       <= LAST_DIR;
      walked      <= 1'b0;
      mask        <= '0;
      ped_pending <= '0;
      red         <= '1;
      ylw         <= '0;
      grn         <= '0;
      walk        <= '0;
      debug       <= 1'b1;
    end else begin
      state       <= state_nx;
      phase       <= phase_nx;
      walked      <= walked_nx;
      mask        <= mask_nx;
      ped_pending <= pend_nx;
      red         <= red_nx;
      ylw         <= ylw_nx;
      grn         <= grn_nx;
      walk        <= walk_nx;
      debug       <= debug_nx;
    end
  end

endmodule

// File: tb/tb_traffic_light_multi.sv
// Bench for traffic_light_multi: a 2-approach instance with directed scenarios
// and a 3-approach instance under random tick/request traffic, both tracked by
// a tick-counting phase model.
module tb_traffic_light_multi;

  localparam int N3 = 3, G3 = 3, Y3 = 2, A3 = 2, W3 = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_a = 1'b0, tick_b = 1'b0;
  logic [1:0] req_a = '0;
  logic [2:0] req_b = '0;

  logic [1:0] red_a, ylw_a, grn_a, walk_a, pend_a;
  logic [0:0] phase_a;
  logic       debug_a;
  logic [2:0] red_b, ylw_b, grn_b, walk_b, pend_b;
  logic [1:0] phase_b;
  logic       debug_b;

  int vectors = 0, miscompares = 0;
  bit checking = 1'b0, run_b = 1'b0, last_rst = 1'b1;
  logic [1:0] prev_b = 2'd2;

  always #5 clk = ~clk;

  traffic_light_multi u_a (
    .clk(clk), .reset(reset), .tick(tick_a), .ped_req(req_a),
    .red(red_a), .ylw(ylw_a), .grn(grn_a), .walk(walk_a),
    .ped_pending(pend_a), .phase(phase_a), .debug(debug_a)
  );

  traffic_light_multi #(
    .NUM_DIRS(N3), .GRN_TICKS(G3), .YLW_TICKS(Y3), .ALLRED_TICKS(A3), .WALK_TICKS(W3)
  ) u_b (
    .clk(clk), .reset(reset), .tick(tick_b), .ped_req(req_b),
    .red(red_b), .ylw(ylw_b), .grn(grn_b), .walk(walk_b),
    .ped_pending(pend_b), .phase(phase_b), .debug(debug_b)
  );

  // Model: kind 0=all-red,1=green,2=yellow,3=walk; left = ticks still owed.
  int p_nd[2] = '{2, N3};
  int p_g[2]  = '{8, G3};
  int p_y[2]  = '{3, Y3};
  int p_a[2]  = '{1, A3};
  int p_w[2]  = '{6, W3};
  int m_kind[2], m_left[2], m_phase[2];
  bit m_walked[2];
  logic [2:0] m_pend[2], m_mask[2];

  task automatic model_step(input int i, input bit rst, input bit tk, input logic [2:0] rq);
    logic [2:0] clr;
    clr = '0;
    if (rst) begin
      m_kind[i] = 0; m_left[i] = p_a[i]; m_phase[i] = p_nd[i] - 1;
      m_walked[i] = 1'b0; m_pend[i] = '0; m_mask[i] = '0;
    end else begin
      if (tk) begin
        m_left[i]--;
        if (m_left[i] == 0) begin
          case (m_kind[i])
            1: begin m_kind[i] = 2; m_left[i] = p_y[i]; end
            2: begin m_kind[i] = 0; m_left[i] = p_a[i]; end
            3: begin m_kind[i] = 0; m_left[i] = p_a[i]; m_walked[i] = 1'b1; end
            default: begin
              if (!m_walked[i] && m_pend[i] != 0) begin
                m_kind[i] = 3; m_left[i] = p_w[i]; m_mask[i] = m_pend[i]; clr = m_pend[i];
              end else begin
                m_kind[i] = 1; m_left[i] = p_g[i];
                m_phase[i] = (m_phase[i] + 1) % p_nd[i]; m_walked[i] = 1'b0;
              end
            end
          endcase
        end
      end
      m_pend[i] = (m_pend[i] & ~clr) | rq;
    end
  endtask

  function automatic logic [17:0] model_out(input int i);
    logic [2:0] sel, all, g, y, r, w;
    logic dbg;
    sel = 3'b001 << m_phase[i];
    all = (i == 0) ? 3'b011 : 3'b111;
    g   = (m_kind[i] == 1) ? sel : 3'b000;
    y   = (m_kind[i] == 2) ? sel : 3'b000;
    r   = all & ~(g | y);
    w   = (m_kind[i] == 3) ? m_mask[i] : 3'b000;
    dbg = (m_kind[i] == 0) || (m_kind[i] == 3);
    return {r, y, g, w, m_pend[i], 2'(m_phase[i]), dbg};
  endfunction

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got=%h expected=%h", nm, $time, got, exp);
    end
  endtask

  always @(posedge clk) begin
    model_step(0, reset, tick_a, {1'b0, req_a});
    model_step(1, reset, tick_b, req_b);
    last_rst = reset;
  end

  always @(negedge clk) begin
    if (checking) begin
      cmp("model_a", {1'b0, red_a, 1'b0, ylw_a, 1'b0, grn_a, 1'b0, walk_a, 1'b0, pend_a,
                      1'b0, phase_a, debug_a}, model_out(0));
      cmp("model_b", {red_b, ylw_b, grn_b, walk_b, pend_b, phase_b, debug_b}, model_out(1));
      cmp("onehot_b", 32'($countones(grn_b | ylw_b) <= 1), 32'd1);
      if (walk_b != 3'b000) cmp("walk_red_b", red_b, 3'b111);
      for (int d = 0; d < N3; d++)
        cmp("lamp_b", int'(red_b[d]) + int'(ylw_b[d]) + int'(grn_b[d]), 1);
      if (!last_rst && phase_b != prev_b)
        cmp("rot_b", phase_b, (prev_b == 2'd2) ? 2'd0 : prev_b + 2'd1);
      prev_b = phase_b;
    end
  end

  initial begin
    wait (run_b);
    while (run_b) begin
      @(negedge clk);
      tick_b = ($urandom_range(0, 9) < 7);
      for (int d = 0; d < N3; d++) req_b[d] = ($urandom_range(0, 19) == 0);
    end
  end

  task automatic nx(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic restart();
    reset = 1'b1;
    nx(1);
    reset = 1'b0;
  endtask

  initial begin
    int c_g0, c_y0, c_g1;
    // Scenario 1: reset release and a full rotation with no requests.
    nx(1);
    checking = 1'b1;
    reset = 1'b0; tick_a = 1'b1; run_b = 1'b1;
    cmp("rst_red", red_a, 2'b11);
    cmp("rst_phase", phase_a, 1'b1);
    cmp("rst_dbg_pend", {debug_a, pend_a, grn_a, walk_a}, 7'b1000000);
    nx(1);
    cmp("g0_first", {grn_a, red_a, phase_a, debug_a}, 6'b01_10_0_0);
    nx(7);  cmp("g0_last", grn_a, 2'b01);
    nx(1);  cmp("y0_first", {ylw_a, red_a}, 4'b01_10);
    nx(3);  cmp("ar_after_y0", {red_a, ylw_a, debug_a}, 5'b11_00_1);
    nx(1);  cmp("g1_first", {grn_a, phase_a}, 3'b10_1);
    cmp("model_pin_phase", m_phase[0], 1);
    nx(12); cmp("wrap_g0", {grn_a, phase_a}, 3'b01_0);
    // Scenario 2: single-cycle request during green of approach 0.
    nx(1);  req_a = 2'b10;
    nx(1);  req_a = 2'b00;
    cmp("pend_rise", pend_a, 2'b10);
    nx(9);  cmp("ar_before_walk", {red_a, walk_a, pend_a}, 6'b11_00_10);
    nx(1);  cmp("walk_entry", {walk_a, red_a, pend_a, debug_a}, 7'b10_11_00_1);
    cmp("model_pin_kind", m_kind[0], 3);
    nx(5);  cmp("walk_last", walk_a, 2'b10);
    nx(1);  cmp("ar_after_walk", {red_a, walk_a}, 4'b11_00);
    nx(1);  cmp("g1_after_walk", {grn_a, phase_a}, 3'b10_1);
    // Scenario 5: reset in the middle of yellow discards a pending request.
    restart();
    nx(8);  req_a = 2'b10;
    nx(1);  req_a = 2'b00;
    cmp("mid_y0", {ylw_a, pend_a}, 4'b01_10);
    reset = 1'b1;
    nx(1);
    cmp("mid_reset", {red_a, ylw_a, grn_a, walk_a, pend_a, phase_a, debug_a}, 12'b11_00_00_00_00_1_1);
    reset = 1'b0;
    nx(1);  cmp("restart_g0", {grn_a, phase_a}, 3'b01_0);
    // Scenario 4: request held across the walk-entry edge is served twice.
    restart();
    nx(2);  req_a = 2'b01;
    nx(11); cmp("held_walk1", {walk_a, pend_a}, 4'b01_01);
    nx(1);  req_a = 2'b00;
    nx(18); cmp("held_walk2", {walk_a, pend_a}, 4'b01_00);
    nx(7);  cmp("held_g0", {grn_a, phase_a}, 3'b01_0);
    // Scenario 3: tick every 4th cycle stretches and freezes the phases.
    restart();
    c_g0 = 0; c_y0 = 0; c_g1 = 0;
    for (int k = 0; k < 90; k++) begin
      if (grn_a == 2'b01) c_g0++;
      if (ylw_a == 2'b01) c_y0++;
      if (grn_a == 2'b10) c_g1++;
      tick_a = (k % 4 == 0);
      nx(1);
    end
    cmp("slow_green0", c_g0, 32);
    cmp("slow_yellow0", c_y0, 12);
    cmp("slow_green1", c_g1, 32);
    tick_a = 1'b1;
    // Long random soak for the 3-approach instance.
    nx(3000);
    run_b = 1'b0;
    checking = 1'b0;
    nx(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
